// File: rtl/eth_type_demux.sv
// eth_type_demux: classifies frames by eth_type and routes header and payload to one of M_COUNT channels
// Ports: s_eth_hdr_* / s_eth_payload_axis_* carry the input frame. The m_eth_* outputs carry shared
// header and payload data, with valid/ready separate for each channel. ch_enable is the runtime channel
// mask. drop_count is a saturating count of dropped frames. busy is high while a frame is in flight.
module eth_type_demux #(
  parameter int                    M_COUNT        = 2,
  parameter logic [M_COUNT*16-1:0] TYPE_LIST      = {16'h0806, 16'h0800},
  parameter bit                    DEFAULT_ENABLE = 1'b0,
  parameter int                    DEFAULT_PORT   = 0,
  parameter int                    DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_eth_hdr_valid,
  output logic                      s_eth_hdr_ready,
  input  logic [47:0]               s_eth_dest_mac,
  input  logic [47:0]               s_eth_src_mac,
  input  logic [15:0]               s_eth_type,
  input  logic [7:0]                s_eth_payload_axis_tdata,
  input  logic                      s_eth_payload_axis_tvalid,
  output logic                      s_eth_payload_axis_tready,
  input  logic                      s_eth_payload_axis_tlast,
  input  logic                      s_eth_payload_axis_tuser,
  output logic [M_COUNT-1:0]        m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]        m_eth_hdr_ready,
  output logic [47:0]               m_eth_dest_mac,
  output logic [47:0]               m_eth_src_mac,
  output logic [15:0]               m_eth_type,
  output logic [7:0]                m_eth_payload_axis_tdata,
  output logic [M_COUNT-1:0]        m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]        m_eth_payload_axis_tready,
  output logic                      m_eth_payload_axis_tlast,
  output logic                      m_eth_payload_axis_tuser,
  input  logic [M_COUNT-1:0]        ch_enable,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      busy
);
  localparam int SW = M_COUNT > 1 ? $clog2(M_COUNT) : 1;
  typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;
  state_t                    r_state;
  logic [SW-1:0]             r_sel, w_match_idx, w_next_sel;
  logic [M_COUNT-1:0]        r_hdr_valid, w_sel_oh;
  logic [47:0]               r_dest, r_src;
  logic [15:0]               r_type;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
  logic                      w_match, w_def, w_hdr_hs, w_last_hs;
  // Descending scan so the lowest matching enabled index is the one left standing
  always_comb begin
    w_match = 1'b0;
    w_match_idx = '0;
    for (int i = M_COUNT - 1; i >= 0; i--)
      if (s_eth_type == TYPE_LIST[16*i +: 16] && ch_enable[i]) begin
        w_match = 1'b1;
        w_match_idx = SW'(i);
      end
  end
  assign w_def       = DEFAULT_ENABLE && ch_enable[DEFAULT_PORT];
  assign w_next_sel  = w_match ? w_match_idx : SW'(DEFAULT_PORT);
  assign w_sel_oh    = M_COUNT'(1) << r_sel;
  assign w_hdr_hs    = s_eth_hdr_valid && s_eth_hdr_ready;
  assign w_last_hs   = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready && s_eth_payload_axis_tlast;
  assign s_eth_hdr_ready           = r_state == IDLE;
  assign s_eth_payload_axis_tready = r_state == DROP ? 1'b1 :
                                     r_state == PASS ? m_eth_payload_axis_tready[r_sel] : 1'b0;
  assign m_eth_payload_axis_tvalid = (r_state == PASS && s_eth_payload_axis_tvalid) ? w_sel_oh : '0;
  assign m_eth_payload_axis_tdata  = s_eth_payload_axis_tdata;
  assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser;
  assign m_eth_hdr_valid = r_hdr_valid;
  assign m_eth_dest_mac  = r_dest;
  assign m_eth_src_mac   = r_src;
  assign m_eth_type      = r_type;
  assign drop_count      = r_drop_cnt;
  assign busy            = r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_hdr_valid <= '0;
      r_dest      <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_drop_cnt  <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_hdr_hs) begin
            r_dest <= s_eth_dest_mac;
            r_src  <= s_eth_src_mac;
            r_type <= s_eth_type;
            if (w_match || w_def) begin
              r_sel       <= w_next_sel;
              r_hdr_valid <= M_COUNT'(1) << w_next_sel;
              r_state     <= HDR;
            end else begin
              r_state <= DROP;
              if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
            end
          end
        HDR:
          if (m_eth_hdr_ready[r_sel]) begin
            r_hdr_valid <= '0;
            r_state     <= PASS;
          end
        PASS, DROP: if (w_last_hs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_eth_type_demux.sv
// tb_eth_type_demux: table-driven bench for eth_type_demux over two configurations sharing one stimulus
module tb_eth_type_demux;
  logic clk = 1'b0, rst = 1'b1, dsel = 1'b0;
  logic s_hdr_valid = 1'b0;
  logic [47:0] s_dest = '0, s_src = '0;
  logic [15:0] s_type = '0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [1:0] m_hdr_ready = '0, m_tready = '0, ch_enable = 2'b11;
  logic a_hdr_ready, b_hdr_ready, a_tready, b_tready, a_tlast, b_tlast, a_tuser, b_tuser, a_busy, b_busy;
  logic [1:0] a_hdr_valid, b_hdr_valid, a_tvalid, b_tvalid;
  logic [47:0] a_dest, b_dest, a_src, b_src;
  logic [15:0] a_type, b_type, b_cnt;
  logic [7:0] a_tdata, b_tdata;
  logic [1:0] a_cnt;
  logic hdr_ready, tready, tlast, tuser, busy;
  logic [1:0] hdr_valid, tvalid;
  logic [47:0] dest, src;
  logic [15:0] etype, cnt;
  logic [7:0] tdata;
  int n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  eth_type_demux #(.M_COUNT(2), .TYPE_LIST({16'h0800, 16'h0806}), .DEFAULT_ENABLE(1'b0),
                   .DEFAULT_PORT(0), .DROP_CNT_WIDTH(2)) u_a (
    .clk(clk), .rst(rst), .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(a_tready), .s_eth_payload_axis_tlast(s_tlast),
    .s_eth_payload_axis_tuser(s_tuser), .m_eth_hdr_valid(a_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(a_dest), .m_eth_src_mac(a_src), .m_eth_type(a_type),
    .m_eth_payload_axis_tdata(a_tdata), .m_eth_payload_axis_tvalid(a_tvalid),
    .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(a_tlast),
    .m_eth_payload_axis_tuser(a_tuser), .ch_enable(ch_enable), .drop_count(a_cnt), .busy(a_busy));

  eth_type_demux #(.M_COUNT(2), .TYPE_LIST({16'h0806, 16'h0806}), .DEFAULT_ENABLE(1'b1),
                   .DEFAULT_PORT(1), .DROP_CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(b_tready), .s_eth_payload_axis_tlast(s_tlast),
    .s_eth_payload_axis_tuser(s_tuser), .m_eth_hdr_valid(b_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(b_dest), .m_eth_src_mac(b_src), .m_eth_type(b_type),
    .m_eth_payload_axis_tdata(b_tdata), .m_eth_payload_axis_tvalid(b_tvalid),
    .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(b_tlast),
    .m_eth_payload_axis_tuser(b_tuser), .ch_enable(ch_enable), .drop_count(b_cnt), .busy(b_busy));

  assign hdr_ready = dsel ? b_hdr_ready : a_hdr_ready;
  assign tready    = dsel ? b_tready : a_tready;
  assign tlast     = dsel ? b_tlast : a_tlast;
  assign tuser     = dsel ? b_tuser : a_tuser;
  assign busy      = dsel ? b_busy : a_busy;
  assign hdr_valid = dsel ? b_hdr_valid : a_hdr_valid;
  assign tvalid    = dsel ? b_tvalid : a_tvalid;
  assign dest      = dsel ? b_dest : a_dest;
  assign src       = dsel ? b_src : a_src;
  assign etype     = dsel ? b_type : a_type;
  assign tdata     = dsel ? b_tdata : a_tdata;
  assign cnt       = dsel ? b_cnt : {14'd0, a_cnt};

  typedef struct {
    bit rst;
    bit dut;
    logic [15:0] etype;
    int len;
    logic [1:0] en;
    int ch;
    int cnt;
    bit bp;
    bit tog;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [1:0] oh;
    logic [3:0] pat;
    logic [7:0] expd;
    bit ok;
    int k, cyc;
    pat = 4'b1001;
    if (v.rst) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    dsel = v.dut;
    ch_enable = v.en;
    oh = v.ch < 0 ? 2'b00 : 2'(2'b01 << v.ch);
    s_hdr_valid = 1'b1;
    s_type = v.etype;
    s_dest = {32'hA0B0C0D0, v.etype};
    s_src = {v.etype, 32'h11223344};
    m_hdr_ready = 2'b00;
    #1 check("hdr_ready_idle", hdr_ready, 1);
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    s_type = '0;
    s_dest = '0;
    s_src = '0;
    if (v.tog) ch_enable = ch_enable ^ 2'b11;
    #1;
    check("hdr_valid", hdr_valid, oh);
    check("busy_hdr", busy, 1);
    check("hdr_ready_busy", hdr_ready, 0);
    if (v.ch >= 0) begin
      check("m_type", etype, v.etype);
      check("m_macs", {dest[15:0], src[47:32]}, {v.etype, v.etype});
      m_hdr_ready = ~oh;
      @(posedge clk); #1;
      check("hdr_hold", hdr_valid, oh);
      m_hdr_ready = oh;
      @(posedge clk); #1;
      m_hdr_ready = 2'b00;
      check("hdr_done", hdr_valid, 0);
    end
    ok = 1'b1;
    k = 0;
    cyc = 0;
    while (k < v.len && cyc < 200) begin
      expd = 8'(k * 3 + v.len);
      s_tvalid = 1'b1;
      s_tdata = expd;
      s_tlast = k == v.len - 1;
      s_tuser = k == v.len - 1;
      m_tready = v.bp ? {2{pat[cyc % 4]}} : 2'b11;
      #1;
      if (v.ch < 0) ok &= tvalid == 2'b00 && tready;
      else ok &= tvalid == oh && tdata == expd && tlast == (k == v.len - 1) &&
                 tuser == (k == v.len - 1) && tready == m_tready[v.ch];
      if (tready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    m_tready = 2'b00;
    #1;
    check("beats_ok", ok, 1);
    check("beats", k, v.len);
    check("cycles", cyc, v.bp ? 20 : v.len);
    check("busy_after_last", busy, 0);
    check("drop_count", cnt, v.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0]  = '{1, 0, 16'h0806, 28, 2'b11, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 16'h0800, 20, 2'b11, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 16'h86DD, 40, 2'b11, -1, 1, 0, 0};
    tbl[3]  = '{0, 0, 16'h0806, 8, 2'b10, -1, 2, 0, 0};
    tbl[4]  = '{0, 0, 16'h0800, 10, 2'b11, 1, 2, 1, 0};
    tbl[5]  = '{0, 0, 16'h0800, 6, 2'b11, 1, 2, 0, 1};
    tbl[6]  = '{0, 0, 16'h0806, 1, 2'b11, 0, 2, 0, 0};
    tbl[7]  = '{0, 0, 16'h0800, 3, 2'b00, -1, 3, 0, 0};
    tbl[8]  = '{0, 0, 16'h0800, 3, 2'b00, -1, 3, 0, 0};
    tbl[9]  = '{0, 0, 16'h86DD, 2, 2'b11, -1, 3, 0, 0};
    tbl[10] = '{0, 0, 16'h0806, 2, 2'b01, 0, 3, 0, 0};
    tbl[11] = '{1, 1, 16'h1234, 12, 2'b11, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 16'h0806, 5, 2'b11, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 16'h0806, 5, 2'b10, 1, 0, 0, 0};
    tbl[14] = '{0, 1, 16'h1234, 4, 2'b01, -1, 1, 0, 0};
    tbl[15] = '{0, 1, 16'h0800, 4, 2'b10, 1, 1, 0, 0};
    s_tvalid = 1'b1;
    #3;
    check("rst_a_valids", {a_hdr_valid, a_tvalid}, 0);
    check("rst_b_valids", {b_hdr_valid, b_tvalid}, 0);
    check("rst_busy", {a_busy, b_busy}, 0);
    check("rst_cnt", {a_cnt, b_cnt}, 0);
    check("rst_hdr_regs", {a_type, a_dest, b_src}, 0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("hdr_ready_after_rst", {a_hdr_ready, b_hdr_ready}, 2'b11);
    for (int i = 0; i < 16; i++) run(tbl[i]);
    // Reset on beat 5 of a 20-beat IP frame on the first configuration
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dsel = 1'b0;
    ch_enable = 2'b11;
    s_hdr_valid = 1'b1;
    s_type = 16'h0800;
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
    m_hdr_ready = 2'b10;
    @(posedge clk); #1;
    m_hdr_ready = 2'b00;
    m_tready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_tvalid = 1'b1;
      s_tdata = 8'(k);
      @(posedge clk); #1;
    end
    s_tdata = 8'd4;
    #1 check("pre_rst_tvalid", tvalid, 2'b10);
    rst = 1'b1;
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_busy_mid", busy, 0);
    check("rst_tready", tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("stall_tready", tready, 0);
    check("stall_hdr_ready", hdr_ready, 1);
    @(posedge clk); #1;
    check("stall_tready2", tready, 0);
    check("stall_busy", busy, 0);
    s_tvalid = 1'b0;
    v = '{0, 0, 16'h0806, 3, 2'b11, 0, 0, 0, 0};
    run(v);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/eth_type_demux.md
Name: eth_type_demux

Overview:
- Parametrised Ethernet-frame demultiplexer that classifies each incoming frame by eth_type and routes the header and payload to one of M_COUNT output channels.
- Unmatched or disabled frames go either to a default channel or are dropped and counted.
- Sits between the MAC-side eth_rx path and the protocol blocks (IP, ARP, future PTP/VLAN handlers). It is the N-way successor of the fixed IP/ARP two-way classifier.
- Unlike that classifier, the header is registered, channel selection is held for the whole frame by an explicit state machine, and runtime channel enables plus a drop counter are provided.

Parameters:
- M_COUNT, 2, number of output channels (1..8).
- TYPE_LIST, {16'h0806,16'h0800}, M_COUNT*16 packed eth_type values; channel i matches TYPE_LIST[16*i +: 16].
- DEFAULT_ENABLE, 0, 1 = unmatched frames go to channel DEFAULT_PORT; 0 = unmatched frames are dropped.
- DEFAULT_PORT, 0, default channel index (< M_COUNT).
- DROP_CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_eth_hdr_valid / s_eth_hdr_ready  in/out  1/1  input header handshake.
- s_eth_dest_mac, s_eth_src_mac, s_eth_type  in  48/48/16  input header fields.
- s_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  input payload.
- m_eth_hdr_valid / m_eth_hdr_ready  out/in  M_COUNT/M_COUNT  per-channel header handshake.
- m_eth_dest_mac, m_eth_src_mac, m_eth_type  out  48/48/16  shared registered header fields.
- m_eth_payload_axis_tdata  out  8  shared payload data.
- m_eth_payload_axis_tvalid/tready  out/in  M_COUNT/M_COUNT  per-channel payload handshake.
- m_eth_payload_axis_tlast, m_eth_payload_axis_tuser  out  1/1  shared payload sideband.
- ch_enable  in  M_COUNT  runtime channel enable mask.
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped frames.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, sel=0.
  - All m_*valid=0, header field registers=0, drop_count=0, busy=0.
  - s_eth_hdr_ready=1 once rst is deasserted.
- States: IDLE, HDR, PASS, DROP.
- IDLE:
  - s_eth_hdr_ready=1; s_eth_payload_axis_tready=0.
  - On a header handshake, compute match = lowest index i with s_eth_type==TYPE_LIST[i] and ch_enable[i]=1.
  - If a match exists: sel=i, latch header fields, go to HDR.
  - Else if DEFAULT_ENABLE=1 and ch_enable[DEFAULT_PORT]=1: sel=DEFAULT_PORT, go to HDR.
  - Else go to DROP and increment drop_count in the same cycle; the counter saturates at all-ones.
- HDR:
  - m_eth_hdr_valid[sel]=1 starting the cycle after the input header handshake (1-cycle header latency); all other bits are 0.
  - Header fields are stable throughout.
  - On m_eth_hdr_ready[sel]=1, drop hdr_valid and go to PASS next cycle.
  - Payload tready=0 in this state.
- PASS:
  - m_eth_payload_axis_tvalid[sel] = s_eth_payload_axis_tvalid; all other bits are 0.
  - s_eth_payload_axis_tready = m_eth_payload_axis_tready[sel].
  - tdata, tlast and tuser pass through combinationally.
  - On a handshake with tlast=1, go to IDLE.
- DROP:
  - s_eth_payload_axis_tready=1 and all m_*valid=0.
  - On a handshake with tlast=1, go to IDLE.
- s_eth_hdr_ready=0 in HDR, PASS and DROP, so the next header is accepted no earlier than the cycle after the tlast handshake.
- ch_enable and TYPE_LIST are sampled only at header acceptance; changing ch_enable mid-frame has no effect on the frame in flight.
- Duplicate entries in TYPE_LIST: the lowest index wins.
- tuser=1 on tlast is forwarded unchanged; it does not count as a drop.
- Payload without a preceding header stalls (tready=0 in IDLE).
- Reset mid-frame:
  - Immediate return to IDLE; all valids deassert asynchronously.
  - Any remaining payload beats of the interrupted frame stall until a new header is accepted.
- drop_count holds at its maximum value; it never wraps.

Test Plan:
- ARP then IP: eth_type 0x0806 with a 28-byte payload, then 0x0800 with 20 bytes, ch_enable=2'b11. Required: ARP on channel 0 and IP on channel 1, header valid 1 cycle after acceptance, byte-exact payloads, drop_count=0.
- Unknown type, drop path: eth_type 0x86DD with 40 bytes, DEFAULT_ENABLE=0. Required: all 40 beats accepted with tready=1, no m valid asserted, drop_count=1, busy falls the cycle after tlast.
- Default routing: DEFAULT_ENABLE=1, DEFAULT_PORT=1, eth_type 0x1234. Required: frame appears on channel 1 with m_eth_type=0x1234.
- Disabled channel: ch_enable=2'b10, ARP frame. Required: frame dropped, drop_count increments; toggling ch_enable mid-IP-frame does not affect that frame.
- Backpressure: channel 1 m_ready toggles 1,0,0,1 on a 10-byte IP frame. Required: s_tready mirrors m_ready[1], no beat lost or duplicated, tlast on byte 10.
- Reset and saturation: assert rst on beat 5 of 20. Required: valids drop immediately and state=IDLE. With DROP_CNT_WIDTH=2 and 5 dropped frames, drop_count=3.
